bcd2bin: RTL and testbench
==========================

// Module: bcd2bin
// PURPOSE
//  Sequential packed-BCD to binary converter; the inverse companion of bin2bcd.
//  Uses reverse double-dabble: shift right one bit per cycle, then subtract 3 from any nibble >= 8.
//  Sits between decimal keypad/display-side logic and the binary datapath.
//  One conversion in flight; 1-cycle valid strobes on input and output.
// PARAMETERS
//  DIGITS  4   number of BCD digits on the input (4 bits each)
//  BIN_W   14  output width; must satisfy 2**BIN_W > 10**DIGITS - 1 (14 for 4 digits)
// PORTS
//  clk      in   1           system clock, rising edge
//  rst_n    in   1           asynchronous active-low reset
//  bcd      in   4*DIGITS    packed BCD, digit 0 in bits [3:0]; sampled only on acceptance
//  bcd_vld  in   1           1-cycle request strobe
//  bin      out  BIN_W       binary result, held until next result
//  bin_vld  out  1           1-cycle result strobe
//  busy     out  1           high while a conversion is in progress
//  err      out  1           invalid-digit flag, qualified by bin_vld
// BEHAVIOUR
//  One clock (clk); reset is asynchronous, active-low (rst_n).
//  Reset: state=IDLE; bin=0, bin_vld=0, busy=0, err=0; shift regs and counter cleared.
//  FSM IDLE/SHIFT; busy = (state==SHIFT), driven from a register.
//  IDLE:
//   - A bcd_vld seen at edge N is accepted.
//   - Load bcd_sr<=bcd, bin_sr<=0, cnt<=0 (cnt is $clog2(BIN_W+1) bits); go to SHIFT.
//  SHIFT, each edge:
//   - Shift {bcd_sr,bin_sr} right by 1.
//   - Then, per nibble of the shifted bcd_sr: if nibble >= 8, nibble -= 3.
//   - cnt <= cnt+1.
//  Last step (cnt==BIN_W-1, edge N+BIN_W):
//   - bin <= final bin_sr; bin_vld <= 1 for one cycle; go to IDLE.
//   - Latency from acceptance edge to bin_vld edge = BIN_W cycles (14 by default).
//  bcd_vld while busy is ignored, with no queueing; a strobe in the same cycle as
//   the last step is also dropped.
//  Back-to-back throughput: one result per BIN_W+1 cycles.
//  bin holds its last value between conversions; bin_vld is never high two cycles running.
//  rst_n asserted mid-conversion aborts immediately: no bin_vld, state=IDLE on release.
//  Inputs with all digits valid give an exact result, no overflow possible.
//   Max 10**DIGITS-1 fits BIN_W by constraint.
// CONFIGURATION
//  Macro BCD2BIN_CHECK_EN.
//  Defined:
//   - On acceptance, flag any input nibble > 9 in a register.
//   - The conversion still runs full latency.
//   - At the result edge: err=1 and bin=0 if flagged, otherwise err=0 and normal bin.
//   - err updates only on the result edge.
//  Undefined: no check logic; err tied 0; invalid nibbles give unspecified bin.
// STRUCTURE
//  bcd_pkg (shared package):
//   - state typedef {IDLE, SHIFT}
//   - BCD_NIB_W=4, BCD_MAX_DIGIT=4'd9, BCD_ADJ_TH=4'd8, BCD_ADJ_VAL=4'd3
//  Sub-module bcd_digit_adj: 4-bit comb, out = (in >= 8) ? in-3 : in.
//   Instantiated DIGITS times via generate. bin2bcd can reuse the same package.
// TESTING
//  - bcd=16'h0423, 1-cycle bcd_vld at edge N -> bin_vld at N+14 only; bin=423; busy high N..N+13.
//  - 16'h0000 -> bin=0; 16'h9999 -> bin=9999; 16'h0001 -> 1; 16'h1000 -> 1000.
//  - Strobe 16'h0007 while busy with 16'h0423 -> only one result (423); next accepted request converts normally.
//  - rst_n low for 1 cycle at N+5 of a conversion -> no bin_vld; all outputs 0; a fresh request then converts correctly.
//  - BCD2BIN_CHECK_EN defined, bcd=16'h0A12 -> bin_vld with err=1, bin=0; following 16'h0012 -> err=0, bin=12.
//  - Random valid BCD, 1000 back-to-back requests, compared against a decimal model; bin_vld spacing = 15 cycles.

Source files
------------

// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared BCD constants, FSM state type and digit helper for bcd2bin/bin2bcd
package bcd_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int         BCD_NIB_W     = 4;
  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;
  localparam logic [3:0] BCD_ADJ_TH    = 4'd8;
  localparam logic [3:0] BCD_ADJ_VAL   = 4'd3;

  function automatic logic nib_invalid(input logic [BCD_NIB_W-1:0] nib);
    return nib > BCD_MAX_DIGIT;
  endfunction

endpackage

// File: rtl/bcd2bin_if.sv
// rtl/bcd2bin_if.sv - request/result bundle between a BCD producer and the bcd2bin converter
interface bcd2bin_if
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
);

  logic [DIGITS*BCD_NIB_W-1:0] bcd;
  logic                        bcd_vld;
  logic [BIN_W-1:0]            bin;
  logic                        bin_vld;
  logic                        busy;
  logic                        err;

  modport master (
    output bcd, bcd_vld,
    input  bin, bin_vld, busy, err
  );

  modport slave (
    input  bcd, bcd_vld,
    output bin, bin_vld, busy, err
  );

endinterface

// File: rtl/bcd_digit_adj.sv
// rtl/bcd_digit_adj.sv - one-nibble correction after a right shift: values >= 8 drop by 3
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [BCD_NIB_W-1:0] din,
  output logic [BCD_NIB_W-1:0] dout
);

  // A bit shifted in from the next digit weighs 5 in decimal, not 8.
  assign dout = (din >= BCD_ADJ_TH) ? din - BCD_ADJ_VAL : din;

endmodule

// File: rtl/bcd2bin.sv
// rtl/bcd2bin.sv - sequential packed-BCD to binary converter (reverse double-dabble); optional BCD2BIN_CHECK_EN digit check
module bcd2bin
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic      clk,
  input  logic      rst_n,
  bcd2bin_if.slave  s
);

  localparam int BCD_W = DIGITS * BCD_NIB_W;
  localparam int CNT_W = $clog2(BIN_W + 1);

  state_t             state;
  logic [BCD_W-1:0]   bcd_sr;
  logic [BIN_W-1:0]   bin_sr;
  logic [CNT_W-1:0]   cnt;
  logic [BIN_W-1:0]   bin_q;
  logic               bin_vld_q;
  logic               busy_q;

  logic [BCD_W-1:0]   bcd_shift;
  logic [BCD_W-1:0]   bcd_adj;
  logic [BIN_W-1:0]   bin_shift;
  logic               last_step;

  assign {bcd_shift, bin_shift} = {bcd_sr, bin_sr} >> 1;
  assign last_step              = (cnt == CNT_W'(BIN_W - 1));

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .din  (bcd_shift[g*BCD_NIB_W +: BCD_NIB_W]),
      .dout (bcd_adj[g*BCD_NIB_W +: BCD_NIB_W])
    );
  end

`ifdef BCD2BIN_CHECK_EN
  logic bad_in;
  logic bad_q;
  logic err_q;

  always_comb begin
    bad_in = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (nib_invalid(s.bcd[i*BCD_NIB_W +: BCD_NIB_W])) bad_in = 1'b1;
    end
  end

  // The flag rides along with the conversion and only surfaces on the result edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bad_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      if (state == IDLE && s.bcd_vld) bad_q <= bad_in;
      if (state == SHIFT && last_step) err_q <= bad_q;
    end
  end

  assign s.err = err_q;
`else
  logic bad_q;
  assign bad_q = 1'b0;
  assign s.err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bcd_sr    <= '0;
      bin_sr    <= '0;
      cnt       <= '0;
      bin_q     <= '0;
      bin_vld_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      bin_vld_q <= 1'b0;
      case (state)
        IDLE: begin
          if (s.bcd_vld) begin
            bcd_sr <= s.bcd;
            bin_sr <= '0;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          bcd_sr <= bcd_adj;
          bin_sr <= bin_shift;
          cnt    <= cnt + 1'b1;
          // Requests arriving on this edge are dropped: the FSM is still in SHIFT.
          if (last_step) begin
            bin_q     <= bad_q ? '0 : bin_shift;
            bin_vld_q <= 1'b1;
            busy_q    <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign s.bin     = bin_q;
  assign s.bin_vld = bin_vld_q;
  assign s.busy    = busy_q;

endmodule

// File: tb/tb_bcd2bin.sv
// tb/tb_bcd2bin.sv - self-checking bench for bcd2bin against a decimal reference model
module tb_bcd2bin;

  localparam int DIGITS = 4;
  localparam int BIN_W  = 14;
  localparam int LAT    = BIN_W;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bcd2bin_if #(.DIGITS(DIGITS), .BIN_W(BIN_W)) bif ();

  bcd2bin #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .s     (bif.slave)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int bcd_value(input logic [15:0] v);
    int r;
    r = 0;
    for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + int'(v[i*4 +: 4]);
    return r;
  endfunction

  function automatic bit bcd_bad(input logic [15:0] v);
    bit b;
    b = 1'b0;
    for (int i = 0; i < DIGITS; i++) if (v[i*4 +: 4] > 4'd9) b = 1'b1;
    return b;
  endfunction

  function automatic logic [15:0] rand_bcd();
    logic [15:0] r;
    for (int i = 0; i < DIGITS; i++) r[i*4 +: 4] = 4'($urandom_range(0, 9));
    return r;
  endfunction

  // Reference model: one job in flight, result exactly LAT edges after acceptance.
  int   cyc       = 0;
  bit   m_busy    = 1'b0;
  int   m_due     = 0;
  int   m_val     = 0;
  bit   m_bad     = 1'b0;
  int   exp_bin   = 0;
  bit   exp_vld   = 1'b0;
  bit   exp_busy  = 1'b0;
  bit   exp_err   = 1'b0;

  always @(posedge clk) begin
    bit acc;
    cyc++;
    if (!rst_n) begin
      m_busy   = 1'b0;
      exp_bin  = 0;
      exp_vld  = 1'b0;
      exp_busy = 1'b0;
      exp_err  = 1'b0;
    end else begin
      acc     = bif.bcd_vld && !m_busy;
      exp_vld = 1'b0;
      if (m_busy && cyc == m_due) begin
        exp_vld = 1'b1;
        m_busy  = 1'b0;
`ifdef BCD2BIN_CHECK_EN
        exp_err = m_bad;
        exp_bin = m_bad ? 0 : m_val;
`else
        exp_bin = m_val;
`endif
      end
      if (acc) begin
        m_busy = 1'b1;
        m_due  = cyc + LAT;
        m_val  = bcd_value(bif.bcd);
        m_bad  = bcd_bad(bif.bcd);
      end
      exp_busy = m_busy;
    end
  end

  bit bb_mode  = 1'b0;
  int last_vld = 0;
  int dut_vlds = 0;

  always @(negedge clk) begin
    check("bin_vld", 32'(bif.bin_vld), 32'(exp_vld));
    check("busy", 32'(bif.busy), 32'(exp_busy));
    check("bin", 32'(bif.bin), 32'(exp_bin));
    check("err", 32'(bif.err), 32'(exp_err));
    if (bif.bin_vld === 1'b1) begin
      dut_vlds++;
      if (bb_mode && last_vld > 0) check("b2b spacing", 32'(cyc - last_vld), 32'd15);
      last_vld = cyc;
    end
  end

  task automatic request(input logic [15:0] v);
    @(negedge clk);
    #1;
    bif.bcd     = v;
    bif.bcd_vld = 1'b1;
    @(negedge clk);
    #1;
    bif.bcd_vld = 1'b0;
    bif.bcd     = 16'($urandom);
  endtask

  task automatic expect_result(input string name, input int val, input bit err_exp);
    int k;
    k = 0;
    while (bif.bin_vld !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (bif.bin_vld !== 1'b1) begin
      check({name, " timeout"}, 32'd0, 32'd1);
    end else begin
      check(name, 32'(bif.bin), 32'(val));
      check({name, " err"}, 32'(bif.err), 32'(err_exp));
      @(negedge clk);
    end
  endtask

  logic [15:0] tab_in  [4] = '{16'h0000, 16'h9999, 16'h0001, 16'h1000};
  int          tab_out [4] = '{0, 9999, 1, 1000};

  initial begin
    int start;
    int guard;
    bif.bcd     = '0;
    bif.bcd_vld = 1'b0;
    repeat (3) @(negedge clk);
    check("reset bin", 32'(bif.bin), 32'd0);
    check("reset bin_vld", 32'(bif.bin_vld), 32'd0);
    check("reset busy", 32'(bif.busy), 32'd0);
    check("reset err", 32'(bif.err), 32'd0);
    #1 rst_n = 1'b1;

    check("model 0423", 32'(bcd_value(16'h0423)), 32'd423);
    check("model 9999", 32'(bcd_value(16'h9999)), 32'd9999);

    request(16'h0423);
    expect_result("bin 0423", 423, 1'b0);
    for (int i = 0; i < 4; i++) begin
      request(tab_in[i]);
      expect_result($sformatf("bin %h", tab_in[i]), tab_out[i], 1'b0);
    end

    request(16'h0423);
    repeat (3) @(negedge clk);
    request(16'h0007);
    expect_result("collision 0423", 423, 1'b0);
    repeat (20) @(negedge clk);
    check("collision dropped", 32'(bif.bin), 32'd423);
    request(16'h0056);
    expect_result("after collision 0056", 56, 1'b0);

    request(16'h0423);
    repeat (4) @(negedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("abort bin", 32'(bif.bin), 32'd0);
    check("abort busy", 32'(bif.busy), 32'd0);
    #1 rst_n = 1'b1;
    repeat (20) @(negedge clk);
    request(16'h0012);
    expect_result("after abort 0012", 12, 1'b0);

`ifdef BCD2BIN_CHECK_EN
    request(16'h0A12);
    expect_result("invalid 0A12", 0, 1'b1);
    request(16'h0012);
    expect_result("valid 0012", 12, 1'b0);
`endif

    bb_mode  = 1'b1;
    last_vld = 0;
    start    = dut_vlds;
    guard    = 0;
    @(negedge clk);
    #1 bif.bcd_vld = 1'b1;
    while (dut_vlds - start < 1000 && guard < 20000) begin
      bif.bcd = rand_bcd();
      @(negedge clk);
      #1;
      guard++;
    end
    bif.bcd_vld = 1'b0;
    check("b2b result count", 32'(dut_vlds - start), 32'd1000);
    repeat (20) @(negedge clk);
    bb_mode = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
